// File: rtl/uart_rx.sv
// 8N1 UART receiver with 2-flop synchronizer, 3-sample majority vote and FWFT receive FIFO.
// Latency: byte visible on rd_valid_o/rd_data_o 993 cycles after the start edge is first sampled (defaults).
// Backpressure: rd_ready_i pops the FIFO head; a good byte arriving while the FIFO is full (and not popped) is dropped with overflow_o.
module uart_rx #(
    parameter int CLK_HZ     = 12000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       sys_clk_i,
    input  logic       sys_rst_i,
    input  logic       uart_rx_i,
    output logic [7:0] rd_data_o,
    output logic       rd_valid_o,
    input  logic       rd_ready_i,
    output logic       frame_err_o,
    output logic       overflow_o,
    output logic       busy_o
);
    localparam int CPB  = CLK_HZ / BAUD;
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB);
    localparam int AW   = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] C_LAST = CW'(CPB - 1);
    localparam logic [CW-1:0] C_SMP0 = CW'(HALF - 1);
    localparam logic [CW-1:0] C_SMP1 = CW'(HALF);
    localparam logic [CW-1:0] C_DEC  = CW'(HALF + 1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);
    localparam logic [AW:0]   P_ONE  = (AW + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    logic          r_sync1;
    logic          r_sync2;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_smp0;
    logic          r_smp1;
    logic          r_frame_err;
    logic          r_overflow;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;

    logic w_rx_s;
    logic w_maj;
    logic w_dec;
    logic w_push_req;
    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;

    assign w_rx_s = r_sync2;
    // Third sample is the live synchronized line in the decision cycle.
    assign w_maj  = (r_smp0 & r_smp1) | (r_smp0 & w_rx_s) | (r_smp1 & w_rx_s);
    assign w_dec  = (r_cnt == C_DEC);

    // A good stop bit hands the shifted byte to the FIFO in the decision cycle itself.
    assign w_push_req = (r_state == S_STOP) && w_dec && w_maj;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = rd_ready_i && !w_empty;
    assign w_push  = w_push_req && (!w_full || w_pop);

    assign rd_data_o   = r_mem[r_rd_ptr[AW-1:0]];
    assign rd_valid_o  = !w_empty;
    assign frame_err_o = r_frame_err;
    assign overflow_o  = r_overflow;
    assign busy_o      = (r_state != S_IDLE);

    // Two-flop synchronizer; idles high so reset never looks like a start edge.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= uart_rx_i;
            r_sync2 <= r_sync1;
        end
    end

    // Frame FSM: bit timing, majority sampling, data shift and frame-error pulse.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_smp0      <= 1'b1;
            r_smp1      <= 1'b1;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            if (r_state != S_IDLE && r_state != S_WAIT_HIGH) begin
                r_cnt <= (r_cnt == C_LAST) ? '0 : r_cnt + C_ONE;
                if (r_cnt == C_SMP0) r_smp0 <= w_rx_s;
                if (r_cnt == C_SMP1) r_smp1 <= w_rx_s;
            end
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (!w_rx_s) r_state <= S_START;
                end
                S_START: begin
                    if (w_dec && w_maj) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt == C_LAST) begin
                        r_state <= S_DATA;
                        r_bit   <= '0;
                    end
                end
                S_DATA: begin
                    if (w_dec) r_shift <= {w_maj, r_shift[7:1]};
                    if (r_cnt == C_LAST) begin
                        if (r_bit == 3'd7) r_state <= S_STOP;
                        else               r_bit   <= r_bit + 3'd1;
                    end
                end
                S_STOP: begin
                    if (w_dec) begin
                        if (w_maj) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_WAIT_HIGH;
                        end
                    end
                end
                S_WAIT_HIGH: begin
                    if (w_rx_s) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // FIFO pointers and overflow pulse; a pop in the same cycle frees room for a push into a full FIFO.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + P_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + P_ONE;
            r_overflow <= w_push_req && w_full && !w_pop;
        end
    end

    // FIFO storage; contents need no reset since validity comes from the pointers.
    always_ff @(posedge sys_clk_i) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= r_shift;
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver: the receive-side counterpart to the existing `uart` transmitter. It runs on the same 12 MHz system clock, decodes 8N1 serial frames from an asynchronous line, and buffers the bytes in a small first-word-fall-through FIFO. It gives the board a host-to-FPGA command path alongside the existing image-dump TX path.

## Interface
- `CLK_HZ`, 12000000: system clock frequency.
- `BAUD`, 115200: line rate.
  - `CPB = CLK_HZ/BAUD`, truncated (104 at defaults).
  - `HALF = CPB/2`, truncated (52).
- `FIFO_DEPTH`, 4: receive FIFO entries; must be a power of two, ≥2.

Ports:
- `sys_clk_i` in 1: system clock; the block's only clock.
- `sys_rst_i` in 1: reset, synchronous, active-high.
- `uart_rx_i` in 1: asynchronous serial input; idles high.
- `rd_data_o` out 8: FIFO head byte; valid only while `rd_valid_o`.
- `rd_valid_o` out 1: FIFO not empty.
- `rd_ready_i` in 1: pops the head when `rd_valid_o` is 1; ignored when `rd_valid_o` is 0.
- `frame_err_o` out 1: one-cycle pulse when the stop bit is sampled low.
- `overflow_o` out 1: one-cycle pulse when a good byte is dropped because the FIFO is full.
- `busy_o` out 1: high whenever the FSM is not in IDLE.

## Operation
- Synchronizer: 2 flops on `uart_rx_i`, both reset to 1. `rx_s` is the second flop's output; all logic uses `rx_s`.
- Bit counter `cnt` counts 0..CPB-1, then wraps. Bit index `k`: 0 = start, 1–8 = data (LSB first), 9 = stop.
- Sampling: 3 samples per bit, taken at `cnt` = HALF-1, HALF and HALF+1. The bit value is the majority of the three, decided in the `cnt==HALF+1` cycle.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: when `rx_s==0`, go to START with `cnt=0` in the next cycle.
  - START: at the decision cycle, a majority of 1 is a false start → IDLE (no outputs). Otherwise stay until `cnt` wraps, then go to DATA.
  - DATA: at each decision cycle, shift the bit into the shift register at the MSB end (shift right). After the 8th bit period wraps, go to STOP.
  - STOP: at the decision cycle:
    - majority 1: push the byte if the FIFO is not full, otherwise pulse `overflow_o`; go straight to IDLE (no wait for end of stop bit).
    - majority 0: pulse `frame_err_o`, push nothing, go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_s==1`, then go to IDLE. A break condition never produces bytes.
- FIFO, first-word-fall-through:
  - `rd_data_o` shows the head combinationally from the registered read pointer.
  - Push and pop in the same cycle while full: both happen, no overflow.
  - Push while empty: the byte appears on `rd_valid_o` the next cycle.
  - Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2·FIFO_DEPTH. Full and empty are decided by comparing the MSB and the remaining bits.

## Timing
- Reset values:
  - FSM = IDLE; synchronizer = 1; FIFO empty.
  - `rd_valid_o=0`, `frame_err_o=0`, `overflow_o=0`, `busy_o=0`.
  - `rd_data_o` is don't-care while `rd_valid_o=0`.
- Reset mid-frame: the partial byte is discarded, the FIFO is flushed, and no pulses are emitted.
- Let E be the first cycle `uart_rx_i` is sampled low:
  - `rx_s` goes low at E+2.
  - START begins at S = E+3.
  - The decision for bit k is at cycle S + k·CPB + HALF + 1.
  - The start decision is at S+53; the stop decision is at S+989 (defaults).
- The pushed byte is on `rd_valid_o`/`rd_data_o` at S+990, i.e. E+993. `frame_err_o`/`overflow_o` pulse in the cycle after the stop decision (E+993).
- `busy_o` is high from S until the cycle after the stop decision. For a false start it falls at S+54.
- Back-to-back frames: a new start edge is accepted from the first IDLE cycle after the stop decision, so frames tolerate up to about HALF cycles of early start edge.
- Tolerated rate error: ±4% at the defaults, with the sample point within the bit.

## Test plan
- Send 0xA5 at exactly 104 cycles/bit → `rd_data_o=0xA5`; `rd_valid_o` rises at E+993; `frame_err_o` and `overflow_o` stay 0; `busy_o` returns to 0.
- Drive a 20-cycle low glitch on an idle line → no push, no pulses; `busy_o` high from E+3 to E+56, then IDLE.
- Send 0x00 with the stop bit held low, releasing the line 300 cycles later → one `frame_err_o` pulse at E+993; FIFO stays empty; the FSM stays in WAIT_HIGH until release; a following 0x5A is received correctly.
- Send 0x01–0x05 back-to-back with `rd_ready_i=0` → FIFO holds 4 entries and `overflow_o` pulses once on byte 5. Then assert `rd_ready_i` for 4 cycles → reads 0x01, 0x02, 0x03, 0x04, after which `rd_valid_o=0`. Push and pop in the same cycle while full → no overflow and the count is unchanged.
- Send 0x3C at 101 and at 107 cycles/bit (about ±3%) → received correctly both times, with no errors.
- Assert `sys_rst_i` for 1 cycle during data bit 4, with 2 bytes already queued → all outputs go to their reset values and the FIFO is empty. The next full frame (0xC3) is received correctly.
